// File: rtl/normalize_shift.sv
// Post-addition normalization for the binary64 adder: 2-stage valid/ready pipeline that
// left-normalizes the raw significand sum (or right-shifts by one on carry) and fixes the exponent.
module normalize_shift (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [56:0] in_fs,
    input  logic [10:0] in_es,
    input  logic        in_ss,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [55:0] out_fn,
    output logic [10:0] out_e,
    output logic        out_s,
    output logic        out_zero,
    output logic        out_ovf
);

    // Stage 1 state
    logic        v1_q;
    logic [56:0] fs1_q;
    logic [10:0] es1_q;
    logic [10:0] ee1_q;
    logic        ss1_q;
    logic [5:0]  lz1_q;
    logic        carry1_q;
    logic        zero1_q;

    // Stage 2 state
    logic        v2_q;
    logic [55:0] fn2_q;
    logic [10:0] e2_q;
    logic        s2_q;
    logic        zero2_q;
    logic        ovf2_q;

    logic load1;
    logic load2;
    logic accept;

    assign load2  = !v2_q || out_ready;
    assign load1  = !v1_q || load2;
    assign accept = in_valid && load1 && !flush;
    // A flushing cycle discards whatever is offered, so it always reads as ready.
    assign in_ready = flush || !v1_q || !v2_q || out_ready;

    // Leading-zero count of in_fs[55:0]; the highest set bit wins because it is visited last.
    logic [5:0] lz_c;
    always_comb begin
        lz_c = 6'd56;
        for (int i = 0; i < 56; i++) begin
            if (in_fs[i]) begin
                lz_c = 6'(55 - i);
            end
        end
    end

    logic [10:0] ee_c;
    assign ee_c = (in_es == 11'd0) ? 11'd1 : in_es;

    // Stage 2 datapath
    logic [10:0] shift_lim;
    logic [10:0] lz_ext;
    logic [10:0] shift_c;
    logic [55:0] shifted;
    logic [11:0] e_sum;
    logic [10:0] e_norm;
    logic [55:0] fn_c;
    logic [10:0] e_c;
    logic        zero_c;
    logic        ovf_c;

    // Capping the shift at ee-1 keeps the exponent from underflowing below 1.
    assign shift_lim = ee1_q - 11'd1;
    assign lz_ext    = {5'd0, lz1_q};
    assign shift_c   = (lz_ext < shift_lim) ? lz_ext : shift_lim;
    assign shifted   = fs1_q[55:0] << shift_c;
    assign e_norm    = ee1_q - shift_c;
    assign e_sum     = {1'b0, es1_q} + 12'd1;

    always_comb begin
        fn_c   = '0;
        e_c    = '0;
        zero_c = 1'b0;
        ovf_c  = 1'b0;
        if (carry1_q) begin
            fn_c  = {fs1_q[56:2], fs1_q[1] | fs1_q[0]};
            e_c   = e_sum[10:0];
            ovf_c = (e_sum == 12'h7FF);
        end else if (zero1_q) begin
            zero_c = 1'b1;
        end else begin
            fn_c = shifted;
            // Hidden bit still clear after the capped shift means a subnormal result.
            e_c  = shifted[55] ? e_norm : 11'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            fs1_q    <= '0;
            es1_q    <= '0;
            ee1_q    <= '0;
            ss1_q    <= 1'b0;
            lz1_q    <= '0;
            carry1_q <= 1'b0;
            zero1_q  <= 1'b0;
            v2_q     <= 1'b0;
            fn2_q    <= '0;
            e2_q     <= '0;
            s2_q     <= 1'b0;
            zero2_q  <= 1'b0;
            ovf2_q   <= 1'b0;
        end else if (flush) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (load1) begin
                v1_q <= in_valid;
            end
            if (accept) begin
                fs1_q    <= in_fs;
                es1_q    <= in_es;
                ee1_q    <= ee_c;
                ss1_q    <= in_ss;
                lz1_q    <= lz_c;
                carry1_q <= in_fs[56];
                zero1_q  <= (in_fs == 57'd0);
            end
            if (load2) begin
                v2_q <= v1_q;
            end
            if (load2 && v1_q) begin
                fn2_q   <= fn_c;
                e2_q    <= e_c;
                s2_q    <= ss1_q;
                zero2_q <= zero_c;
                ovf2_q  <= ovf_c;
            end
        end
    end

    assign out_valid = v2_q;
    assign out_fn    = fn2_q;
    assign out_e     = e2_q;
    assign out_s     = s2_q;
    assign out_zero  = zero2_q;
    assign out_ovf   = ovf2_q;

endmodule

// File: tb/tb_normalize_shift.sv
// Self-checking bench for normalize_shift: directed latency/edge cases, backpressure, flush,
// async reset, and a long randomized run scored against a behavioural queue model.
module tb_normalize_shift;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [56:0] in_fs;
    logic [10:0] in_es;
    logic        in_ss;
    logic        out_valid;
    logic        out_ready;
    logic [55:0] out_fn;
    logic [10:0] out_e;
    logic        out_s;
    logic        out_zero;
    logic        out_ovf;

    normalize_shift dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fs     (in_fs),
        .in_es     (in_es),
        .in_ss     (in_ss),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fn    (out_fn),
        .out_e     (out_e),
        .out_s     (out_s),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [55:0] fn;
        logic [10:0] e;
        logic        s;
        logic        z;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   tests   = 0;
    int   fails   = 0;
    int   drained = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: shift one place at a time while the hidden bit is clear and the exponent > 1.
    function automatic void model(input logic [56:0] fs, input logic [10:0] es,
                                  output logic [55:0] fn, output logic [10:0] e,
                                  output logic z, output logic o);
        int          ex;
        logic [55:0] v;
        z = 1'b0;
        o = 1'b0;
        if (fs[56]) begin
            fn    = fs[56:1];
            fn[0] = fs[1] | fs[0];
            ex    = int'(es) + 1;
            e     = ex[10:0];
            o     = (ex == 2047);
        end else if (fs == 57'd0) begin
            fn = '0;
            e  = '0;
            z  = 1'b1;
        end else begin
            ex = (es == 11'd0) ? 1 : int'(es);
            v  = fs[55:0];
            while (!v[55] && ex > 1) begin
                v  = v << 1;
                ex = ex - 1;
            end
            if (!v[55]) ex = 0;
            fn = v;
            e  = ex[10:0];
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Scoreboard bookkeeping at the active edge (sees pre-edge values).
    always @(posedge clk) begin
        exp_t x;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                drained++;
            end
            if (in_valid && in_ready) begin
                model(in_fs, in_es, x.fn, x.e, x.z, x.o);
                x.s = in_ss;
                q.push_back(x);
            end
        end
    end

    // Compare process on the falling edge.
    always @(negedge clk) begin
        logic exp_ready;
        if (rst_n) begin
            exp_ready = flush || (q.size() < 2) || out_ready;
            tests++;
            if (in_ready !== exp_ready) begin
                fails++;
                $display("FAIL in_ready: got %b, expected %b", in_ready, exp_ready);
            end
            if (out_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_out: out_valid=1, expected no pending result");
                end else if (out_fn !== q[0].fn || out_e !== q[0].e || out_s !== q[0].s ||
                             out_zero !== q[0].z || out_ovf !== q[0].o) begin
                    fails++;
                    $display("FAIL result: got fn=%h e=%h s=%b z=%b o=%b, expected fn=%h e=%h s=%b z=%b o=%b",
                             out_fn, out_e, out_s, out_zero, out_ovf,
                             q[0].fn, q[0].e, q[0].s, q[0].z, q[0].o);
                end
            end else if (q.size() == 2) begin
                tests++;
                fails++;
                $display("FAIL out_valid_full: got 0, expected 1 with both stages full");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0 && !out_valid) break;
            step();
        end
        chk("idle", {63'd0, (q.size() == 0 && !out_valid)}, 64'd1);
    endtask

    task automatic offer(input logic [56:0] fs, input logic [10:0] es, input logic ss);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_fs    = fs;
        in_es    = es;
        in_ss    = ss;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (in_ready) ok = 1'b1;
            step();
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL offer_timeout: got no accept, expected accept within 50 cycles");
        end
    endtask

    task automatic send_lat(input string name, input logic [56:0] fs, input logic [10:0] es,
                            input logic ss, input logic [55:0] efn, input logic [10:0] ee,
                            input logic ez, input logic eo);
        wait_idle();
        in_valid = 1'b1;
        in_fs    = fs;
        in_es    = es;
        in_ss    = ss;
        #1;
        chk({name, "_ready"}, {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk({name, "_v_at1"}, {63'd0, out_valid}, 64'd0);
        step();
        #1;
        chk({name, "_v_at2"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_fn"}, {8'd0, out_fn}, {8'd0, efn});
        chk({name, "_e"}, {53'd0, out_e}, {53'd0, ee});
        chk({name, "_s"}, {63'd0, out_s}, {63'd0, ss});
        chk({name, "_zero"}, {63'd0, out_zero}, {63'd0, ez});
        chk({name, "_ovf"}, {63'd0, out_ovf}, {63'd0, eo});
    endtask

    function automatic logic [56:0] rand_fs();
        logic [63:0] t;
        logic [56:0] r;
        t = {$urandom(), $urandom()};
        r = t[56:0];
        case ($urandom_range(0, 9))
            0:       r = '0;
            1, 2:    r[56] = 1'b1;
            default: r = r >> $urandom_range(1, 57);
        endcase
        return r;
    endfunction

    function automatic logic [10:0] rand_es();
        logic [31:0] t;
        t = $urandom();
        case ($urandom_range(0, 7))
            0:       return 11'd0;
            1:       return 11'd1;
            2:       return 11'd2;
            3:       return 11'd3;
            4:       return 11'h7FE;
            5:       return 11'h7FF;
            default: return t[10:0];
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] mfn;
        logic [10:0] me;
        logic        mz;
        logic        mo;
        int          d0;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_fs     = '0;
        in_es     = '0;
        in_ss     = 1'b0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_fn", {8'd0, out_fn}, 64'd0);
        chk("rst_out_e", {53'd0, out_e}, 64'd0);
        chk("rst_flags", {60'd0, out_s, out_zero, out_ovf, 1'b0}, 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // Pin the reference model to hand-derived values.
        model({1'b1, 56'h0}, 11'h3FF, mfn, me, mz, mo);
        chk("model_carry_fn", {8'd0, mfn}, 64'h0080_0000_0000_0000);
        chk("model_carry_e", {53'd0, me}, 64'h400);
        model(57'h0_40_0000_0000_0000, 11'h3FF, mfn, me, mz, mo);
        chk("model_lz1_fn", {8'd0, mfn}, 64'h0080_0000_0000_0000);
        chk("model_lz1_e", {53'd0, me}, 64'h3FE);
        model(57'd1 << 50, 11'd2, mfn, me, mz, mo);
        chk("model_sub_fn", {8'd0, mfn}, 64'h0008_0000_0000_0000);
        chk("model_sub_e", {53'd0, me}, 64'h0);
        model({1'b1, 56'h0}, 11'h7FE, mfn, me, mz, mo);
        chk("model_ovf", {52'd0, me, mo}, {52'd0, 11'h7FF, 1'b1});
        model(57'd0, 11'h123, mfn, me, mz, mo);
        chk("model_zero", {52'd0, me, mz}, {52'd0, 11'h0, 1'b1});

        // Directed cases with latency and literal results.
        send_lat("carry", {1'b1, 56'h0}, 11'h3FF, 1'b0, 56'h80_0000_0000_0000, 11'h400, 0, 0);
        send_lat("lz1", 57'h0_40_0000_0000_0000, 11'h3FF, 1'b1, 56'h80_0000_0000_0000,
                 11'h3FE, 0, 0);
        send_lat("subn", 57'd1 << 50, 11'd2, 1'b0, 56'h08_0000_0000_0000, 11'h0, 0, 0);
        send_lat("zero", 57'd0, 11'h3FF, 1'b1, 56'h0, 11'h0, 1, 0);
        send_lat("ovf", {1'b1, 56'h0}, 11'h7FE, 1'b0, 56'h80_0000_0000_0000, 11'h7FF, 0, 1);
        send_lat("sticky", {1'b1, 55'h0, 1'b1}, 11'h10, 1'b0, 56'h80_0000_0000_0001,
                 11'h11, 0, 0);
        send_lat("es0", 57'd1 << 40, 11'd0, 1'b0, 56'd1 << 40, 11'h0, 0, 0);

        // Backpressure: 4 ops, out_ready low for 4 cycles.
        wait_idle();
        d0        = drained;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fs     = 57'h0_80_0000_0000_0001;
        in_es     = 11'h100;
        step();
        in_fs = 57'h0_00_0000_0000_0F00;
        step();
        in_fs = {1'b1, 56'h55};
        in_es = 11'h200;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            chk("bp_held", {63'd0, out_valid}, 64'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_out0", {63'd0, out_valid}, 64'd1);
        step();
        in_fs = 57'h0_00_0300_0000_0000;
        in_es = 11'h7;
        #1;
        chk("bp_rel_out1", {63'd0, out_valid}, 64'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk("bp_rel_out2", {63'd0, out_valid}, 64'd1);
        step();
        #1;
        chk("bp_rel_out3", {63'd0, out_valid}, 64'd1);
        step();
        #1;
        chk("bp_done", {63'd0, out_valid}, 64'd0);
        chk("bp_count", 64'(drained - d0), 64'd4);

        // Flush with both stages full.
        wait_idle();
        out_ready = 1'b0;
        offer(57'h0_00_0000_1234_0000, 11'h50, 1'b1);
        offer(57'h0_10_0000_0000_0000, 11'h51, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_fs    = 57'h0_80_0000_0000_0000;
        #1;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        send_lat("post_flush", 57'h0_20_0000_0000_0000, 11'h40, 1'b1, 56'h80_0000_0000_0000,
                 11'h3E, 0, 0);

        // Asynchronous reset with both stages full.
        wait_idle();
        out_ready = 1'b0;
        offer({1'b1, 56'hFF}, 11'h3, 1'b1);
        offer(57'h0_00_0000_0000_00F0, 11'h300, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_out_fn", {8'd0, out_fn}, 64'd0);
        chk("arst_out_e", {53'd0, out_e}, 64'd0);
        chk("arst_flags", {61'd0, out_s, out_zero, out_ovf}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Randomized traffic with backpressure and occasional flush.
        for (int n = 0; n < 2000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_fs     = rand_fs();
            in_es     = rand_es();
            in_ss     = $urandom_range(0, 1) == 1;
            step();
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
